// File: rtl/cache_if.sv
// Bus bundle between the cache controller and its surroundings: the CPU
// memory-stage port, the external valid/tag/data arrays and main memory.
// The controller connects through the master modport because it masters the
// arrays and the memory port. The environment (CPU, arrays, memory) uses slave.
interface cache_if #(
    parameter int mem_size  = 5,
    parameter int tag_size  = 5,
    parameter int data_size = 32
);
    localparam int addr_size = tag_size + mem_size;

    logic                 cpu_req;
    logic                 cpu_we;
    logic [addr_size-1:0] cpu_addr;
    logic [data_size-1:0] cpu_wdata;
    logic                 cpu_ack;
    logic [data_size-1:0] cpu_rdata;

    logic [mem_size-1:0]  arr_index;
    logic                 valid_rd;
    logic [tag_size-1:0]  tag_rd;
    logic [data_size-1:0] data_rd;
    logic                 valid_we;
    logic                 tag_we;
    logic                 data_we;
    logic                 valid_wdata;
    logic [tag_size-1:0]  tag_wdata;
    logic [data_size-1:0] data_wdata;

    logic                 mem_req;
    logic                 mem_we;
    logic [addr_size-1:0] mem_addr;
    logic [data_size-1:0] mem_wdata;
    logic [data_size-1:0] mem_rdata;
    logic                 mem_ready;

    logic [15:0]          hit_count;
    logic [15:0]          miss_count;

    modport master (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output cpu_ack, cpu_rdata,
        output arr_index,
        input  valid_rd, tag_rd, data_rd,
        output valid_we, tag_we, data_we, valid_wdata, tag_wdata, data_wdata,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready,
        output hit_count, miss_count
    );

    modport slave (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  cpu_ack, cpu_rdata,
        input  arr_index,
        output valid_rd, tag_rd, data_rd,
        input  valid_we, tag_we, data_we, valid_wdata, tag_wdata, data_wdata,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ready,
        input  hit_count, miss_count
    );
endinterface

// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate cache controller.
// Arrays are external (async read, sync write). Memory is a req/ready handshake.
// Hit and miss counters saturate at 16'hFFFF.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for cpu_req; array index follows the live CPU address
// COMPARE   | tag/valid check on the latched index; read hit acks here
// READ_MEM  | read miss refill; arrays written and CPU acked on mem_ready
// WRITE_MEM | write-through to memory; CPU acked on mem_ready
module cache_controller #(
    parameter int mem_size  = 5,
    parameter int tag_size  = 5,
    parameter int data_size = 32
) (
    input  logic     clk,
    input  logic     rst,
    cache_if.master  bus
);
    localparam int addr_size = tag_size + mem_size;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COMPARE   = 2'd1,
        READ_MEM  = 2'd2,
        WRITE_MEM = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [addr_size-1:0] req_addr_q;
    logic                 req_we_q;
    logic [data_size-1:0] req_wdata_q;
    logic [15:0]          hit_count_q, miss_count_q;
    logic                 hit_inc, miss_inc;

    logic [mem_size-1:0]  req_index;
    logic [tag_size-1:0]  req_tag;
    logic                 hit;

    assign req_index = req_addr_q[mem_size-1:0];
    assign req_tag   = req_addr_q[addr_size-1:mem_size];
    assign hit       = bus.valid_rd && (bus.tag_rd == req_tag);

    assign bus.hit_count  = hit_count_q;
    assign bus.miss_count = miss_count_q;

    // State register; async reset abandons any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Request latch: the access is frozen at the sampling edge so later CPU
    // bus changes cannot disturb it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_addr_q  <= '0;
            req_we_q    <= 1'b0;
            req_wdata_q <= '0;
        end else if (state_q == IDLE && bus.cpu_req) begin
            req_addr_q  <= bus.cpu_addr;
            req_we_q    <= bus.cpu_we;
            req_wdata_q <= bus.cpu_wdata;
        end
    end

    // Saturating performance counters, bumped once per access in COMPARE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            if (hit_inc && hit_count_q != 16'hFFFF)
                hit_count_q <= hit_count_q + 16'd1;
            if (miss_inc && miss_count_q != 16'hFFFF)
                miss_count_q <= miss_count_q + 16'd1;
        end
    end

    // Next-state and all bus outputs; every output idles at 0.
    always_comb begin
        state_d         = state_q;
        hit_inc         = 1'b0;
        miss_inc        = 1'b0;
        bus.cpu_ack     = 1'b0;
        bus.cpu_rdata   = '0;
        bus.arr_index   = req_index;
        bus.valid_we    = 1'b0;
        bus.tag_we      = 1'b0;
        bus.data_we     = 1'b0;
        bus.valid_wdata = 1'b0;
        bus.tag_wdata   = '0;
        bus.data_wdata  = '0;
        bus.mem_req     = 1'b0;
        bus.mem_we      = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_wdata   = '0;

        case (state_q)
            IDLE: begin
                bus.arr_index = bus.cpu_addr[mem_size-1:0];
                if (bus.cpu_req) state_d = COMPARE;
            end
            COMPARE: begin
                if (hit) hit_inc  = 1'b1;
                else     miss_inc = 1'b1;
                if (req_we_q) begin
                    // Write hit updates the line in place; a write miss
                    // leaves the arrays alone (no allocate).
                    if (hit) begin
                        bus.data_we    = 1'b1;
                        bus.data_wdata = req_wdata_q;
                    end
                    state_d = WRITE_MEM;
                end else if (hit) begin
                    bus.cpu_ack   = 1'b1;
                    bus.cpu_rdata = bus.data_rd;
                    state_d       = IDLE;
                end else begin
                    state_d = READ_MEM;
                end
            end
            READ_MEM: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = req_addr_q;
                if (bus.mem_ready) begin
                    bus.valid_we    = 1'b1;
                    bus.tag_we      = 1'b1;
                    bus.data_we     = 1'b1;
                    bus.valid_wdata = 1'b1;
                    bus.tag_wdata   = req_tag;
                    bus.data_wdata  = bus.mem_rdata;
                    bus.cpu_ack     = 1'b1;
                    bus.cpu_rdata   = bus.mem_rdata;
                    state_d         = IDLE;
                end
            end
            WRITE_MEM: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = req_addr_q;
                bus.mem_wdata = req_wdata_q;
                if (bus.mem_ready) begin
                    bus.cpu_ack = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with behavioural arrays, a reference
// cache/memory model, and a scoreboard of expected CPU responses.
module tb_cache_controller;
    localparam int MS = 5;
    localparam int TS = 5;
    localparam int DS = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    cache_if #(.mem_size(MS), .tag_size(TS), .data_size(DS)) bus ();

    cache_controller #(.mem_size(MS), .tag_size(TS), .data_size(DS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural arrays: async read, sync write; valid array has its own reset.
    logic [31:0]   valid_arr;
    logic [TS-1:0] tag_arr  [32];
    logic [DS-1:0] data_arr [32];

    always @(posedge clk or posedge rst) begin
        if (rst) valid_arr <= '0;
        else if (bus.valid_we) valid_arr[bus.arr_index] <= bus.valid_wdata;
    end
    always @(posedge clk) begin
        if (bus.tag_we)  tag_arr[bus.arr_index]  <= bus.tag_wdata;
        if (bus.data_we) data_arr[bus.arr_index] <= bus.data_wdata;
    end
    assign bus.valid_rd = valid_arr[bus.arr_index];
    assign bus.tag_rd   = tag_arr[bus.arr_index];
    assign bus.data_rd  = data_arr[bus.arr_index];

    // Reference model
    logic [DS-1:0] ref_mem [1024];
    logic          ref_valid [32];
    logic [TS-1:0] ref_tag [32];
    int            ref_hits = 0;
    int            ref_misses = 0;

    typedef struct {
        logic          we;
        logic [DS-1:0] rdata;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every cpu_ack must match the oldest pending access.
    always begin
        @(negedge clk);
        #2;
        if (bus.cpu_ack === 1'b1) begin
            chk("ack_pending", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                exp_t e;
                e = exp_q.pop_front();
                chk("cpu_rdata", 64'(bus.cpu_rdata), e.we ? 64'd0 : 64'(e.rdata));
            end
        end
    end

    task automatic clear_ref();
        for (int i = 0; i < 32; i++) ref_valid[i] = 1'b0;
        ref_hits   = 0;
        ref_misses = 0;
    endtask

    task automatic access(input logic we, input logic [9:0] addr,
                          input logic [DS-1:0] wdata, input int wait_cyc);
        logic [MS-1:0] idx;
        logic [TS-1:0] tg;
        logic          exp_hit;
        logic [DS-1:0] exp_rd;
        exp_t          e;
        idx     = addr[MS-1:0];
        tg      = addr[9:MS];
        exp_hit = ref_valid[idx] && (ref_tag[idx] == tg);
        exp_rd  = ref_mem[addr];

        @(negedge clk);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
        e.we    = we;
        e.rdata = exp_rd;
        exp_q.push_back(e);
        #1;
        chk("idle_index", 64'(bus.arr_index), 64'(idx));

        // COMPARE cycle; scramble the CPU bus to prove the latch holds.
        @(negedge clk);
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = ~we;
        bus.cpu_addr  = ~addr;
        bus.cpu_wdata = ~wdata;
        #1;
        if (exp_hit) ref_hits++; else ref_misses++;
        chk("cmp_index", 64'(bus.arr_index), 64'(idx));
        chk("cmp_mem_req", 64'(bus.mem_req), 64'd0);
        chk("cmp_ack", 64'(bus.cpu_ack), 64'(!we && exp_hit));
        chk("cmp_fill_we", 64'({bus.valid_we, bus.tag_we}), 64'd0);
        chk("cmp_data_we", 64'(bus.data_we), 64'(we && exp_hit));
        if (we && exp_hit) chk("cmp_data_wdata", 64'(bus.data_wdata), 64'(wdata));

        if (!(!we && exp_hit)) begin
            for (int c = 0; c <= wait_cyc; c++) begin
                @(negedge clk);
                if (c == wait_cyc) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = we ? 32'hBAD0BAD0 : exp_rd;
                end
                #1;
                chk("mem_req", 64'(bus.mem_req), 64'd1);
                chk("mem_we", 64'(bus.mem_we), 64'(we));
                chk("mem_addr", 64'(bus.mem_addr), 64'(addr));
                chk("mem_wdata", 64'(bus.mem_wdata), we ? 64'(wdata) : 64'd0);
                chk("mem_ack", 64'(bus.cpu_ack), 64'(c == wait_cyc));
                if (c == wait_cyc && !we) begin
                    chk("fill_we", 64'({bus.valid_we, bus.tag_we, bus.data_we, bus.valid_wdata}), 64'hF);
                    chk("fill_index", 64'(bus.arr_index), 64'(idx));
                    chk("fill_tag", 64'(bus.tag_wdata), 64'(tg));
                    chk("fill_data", 64'(bus.data_wdata), 64'(exp_rd));
                end else begin
                    chk("mem_arr_we", 64'({bus.valid_we, bus.tag_we, bus.data_we}), 64'd0);
                end
            end
            @(negedge clk);
            bus.mem_ready = 1'b0;
            bus.mem_rdata = '0;
            if (we) begin
                ref_mem[addr] = wdata;
            end else begin
                ref_valid[idx] = 1'b1;
                ref_tag[idx]   = tg;
            end
        end else begin
            @(negedge clk);
        end
        #3;
        chk("idle_ack", 64'(bus.cpu_ack), 64'd0);
        chk("idle_mem_req", 64'(bus.mem_req), 64'd0);
        chk("hit_count", 64'(bus.hit_count), 64'(ref_hits));
        chk("miss_count", 64'(bus.miss_count), 64'(ref_misses));
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        logic [TS-1:0] rt;
        logic [MS-1:0] ri;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = (32'(i) * 32'h01010101) ^ 32'h5A5A0000;
        ref_mem[10'h0A3] = 32'hDEADBEEF;
        clear_ref();

        // Reset state
        @(negedge clk);
        #1;
        chk("rst_ack", 64'(bus.cpu_ack), 64'd0);
        chk("rst_mem_req", 64'(bus.mem_req), 64'd0);
        chk("rst_counts", 64'({bus.hit_count, bus.miss_count}), 64'd0);
        chk("rst_arr_we", 64'({bus.valid_we, bus.tag_we, bus.data_we}), 64'd0);
        chk("rst_index", 64'(bus.arr_index), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        access(1'b0, 10'h0A3, '0, 3);             // cold read miss
        access(1'b0, 10'h0A3, '0, 0);             // read hit
        access(1'b1, 10'h0A3, 32'h12345678, 2);   // write hit
        access(1'b0, 10'h0A3, '0, 0);             // read hit of updated data
        access(1'b0, 10'h0C3, '0, 1);             // conflict miss, same index
        access(1'b0, 10'h0C3, '0, 0);             // hit on new tag
        access(1'b0, 10'h0A3, '0, 0);             // evicted: miss, zero-wait memory
        access(1'b1, 10'h3FF, 32'hCAFEF00D, 1);   // write miss, no allocate
        access(1'b0, 10'h3FF, '0, 2);             // read miss returns written value

        for (int n = 0; n < 24; n++) begin
            rt = 5'($urandom_range(0, 3));
            ri = 5'($urandom_range(0, 3));
            access(1'($urandom_range(0, 1)), {rt, ri}, $urandom, int'($urandom_range(0, 3)));
        end

        // Reset in the middle of a refill
        @(negedge clk);
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 10'h155;
        @(negedge clk);
        bus.cpu_req  = 1'b0;
        @(negedge clk);
        #1;
        chk("rm_mem_req_before", 64'(bus.mem_req), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        clear_ref();
        chk("rm_mem_req", 64'(bus.mem_req), 64'd0);
        chk("rm_counts", 64'({bus.hit_count, bus.miss_count}), 64'd0);
        chk("rm_ack", 64'(bus.cpu_ack), 64'd0);
        chk("rm_arr_we", 64'({bus.valid_we, bus.tag_we, bus.data_we}), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h0BADF00D;
        #1;
        chk("late_ready_ack", 64'(bus.cpu_ack), 64'd0);
        chk("late_ready_req", 64'(bus.mem_req), 64'd0);
        chk("late_ready_we", 64'({bus.valid_we, bus.tag_we, bus.data_we}), 64'd0);
        @(negedge clk);
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;

        access(1'b0, 10'h0A3, '0, 1);             // valid array cleared: miss again
        access(1'b0, 10'h0A3, '0, 0);             // and hit after refill

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cache_controller.md
# cache_controller

Direct-mapped, write-through cache controller that sequences CPU accesses against the cache valid, tag and data arrays and a handshaked main-memory port. It drives the write side of the valid array (index, enable, write value) and consumes its asynchronous read output. Tag and data arrays use the same external, asynchronous-read, synchronous-write style. The block sits between the CPU memory stage and main memory, and keeps saturating hit/miss counters for performance monitoring.

## Interface
- mem_size, 5: index width; the cache holds 2**mem_size lines of one word each.
- tag_size, 5: tag width; CPU word address width is tag_size+mem_size.
- data_size, 32: data word width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cpu_req  in  1  access request; sampled only in IDLE.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  tag_size+mem_size  word address, split as {tag, index}.
- cpu_wdata  in  data_size  write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  data_size  read data; valid only while cpu_ack=1 for a read, 0 otherwise.
- arr_index  out  mem_size  index shared by the valid, tag and data arrays.
- valid_rd  in  1  valid bit at arr_index.
- tag_rd  in  tag_size  tag at arr_index.
- data_rd  in  data_size  data at arr_index.
- valid_we / tag_we / data_we  out  1  array write enables.
- valid_wdata  out  1  valid write value.
- tag_wdata  out  tag_size  tag write value.
- data_wdata  out  data_size  data write value.
- mem_req  out  1  memory request; held until mem_ready.
- mem_we  out  1  memory write.
- mem_addr  out  tag_size+mem_size  memory word address.
- mem_wdata  out  data_size  memory write data.
- mem_rdata  in  data_size  memory read data; valid with mem_ready.
- mem_ready  in  1  memory completion; ignored while mem_req=0.
- hit_count / miss_count  out  16  saturating access counters.

## Operation
- States: IDLE, COMPARE, READ_MEM, WRITE_MEM. Reset state is IDLE.
- Reset values: all outputs 0 and all counters 0. A latched request register holds addr, we and wdata, cleared to 0.
- IDLE:
  - arr_index = cpu_addr index.
  - On cpu_req=1, latch addr/we/wdata and go to COMPARE.
- COMPARE:
  - arr_index = latched index.
  - hit = valid_rd && (tag_rd == latched tag).
  - Read hit: cpu_ack=1, cpu_rdata=data_rd, hit_count+1, go to IDLE.
  - Read miss: miss_count+1, go to READ_MEM.
  - Write hit: data_we=1 with data_wdata=latched wdata (no-allocate write-update), hit_count+1, go to WRITE_MEM.
  - Write miss: miss_count+1, go to WRITE_MEM; arrays untouched.
- READ_MEM:
  - mem_req=1, mem_we=0, mem_addr=latched addr.
  - On mem_ready: valid_we=tag_we=data_we=1, valid_wdata=1, tag_wdata=latched tag, data_wdata=mem_rdata; cpu_ack=1, cpu_rdata=mem_rdata; go to IDLE.
- WRITE_MEM:
  - mem_req=1, mem_we=1, mem_addr=latched addr, mem_wdata=latched wdata.
  - On mem_ready: cpu_ack=1, go to IDLE.
- The controller never writes valid_wdata=0. Invalidation is done only by the valid array's own reset.
- Counters saturate at 16'hFFFF and never wrap.
- All array, memory and CPU outputs are combinational from state and latched request. They are 0 whenever the corresponding enable or strobe is inactive.

## Timing
- Request sampled at edge N (IDLE, cpu_req=1); COMPARE occupies cycle N+1.
- Read hit: cpu_ack in cycle N+1 (1-cycle latency).
- Read or write miss:
  - mem_req rises in cycle N+2 and stays high until the cycle with mem_ready=1, inclusive.
  - Earliest cpu_ack is cycle N+2 (mem_ready already high on the first request cycle).
- Write hit: data array updated at the end of cycle N+1; cpu_ack arrives with mem_ready.
- If cpu_req is still high in IDLE after cpu_ack, it is treated as a new request. Requesters deassert cpu_req in the cycle after cpu_ack.
- cpu_addr/cpu_we/cpu_wdata changes after edge N have no effect on the current access.
- Reset mid-operation: state goes to IDLE immediately (asynchronous), mem_req drops without waiting for mem_ready, no array write and no cpu_ack occur, and counters are cleared.

## Test plan
- After reset with all valid=0: read 0x0A3 (tag 5, index 3) -> miss_count=1, mem_req with mem_addr=0x0A3; mem_ready after 3 cycles with mem_rdata=0xDEADBEEF -> valid/tag/data writes at index 3 and cpu_ack with cpu_rdata=0xDEADBEEF.
- Re-read 0x0A3 -> cpu_ack one cycle after the request with 0xDEADBEEF, hit_count=1, no mem_req.
- Write 0x0A3 with 0x12345678 -> data_we at index 3 in COMPARE, then mem_req/mem_we with mem_wdata=0x12345678 until mem_ready; a following read returns 0x12345678 as a hit.
- Read 0x0C3 (tag 6, same index) -> miss (tag mismatch), refill overwrites index 3 with tag 6; a subsequent read of 0x0A3 misses again.
- Write miss to 0x3FF -> memory write only, no array write enable asserted, miss_count increments.
- Assert rst while in READ_MEM with mem_ready=0 -> mem_req=0 immediately, state IDLE, counters 0; a later mem_ready pulse produces no cpu_ack.
